// File: rtl/jtag_ir_ctrl_pkg.sv
// Shared opcodes, DR-select encoding and capture pattern for the JTAG instruction register.
package jtag_pkg;

    localparam logic [3:0] OP_BYPASS   = 4'h0;
    localparam logic [3:0] OP_SAMPLE   = 4'h1;
    localparam logic [3:0] OP_PRELOAD  = 4'h2;
    localparam logic [3:0] OP_EXTEST   = 4'h3;
    localparam logic [3:0] OP_INTEST   = 4'h4;
    localparam logic [3:0] OP_CLAMP    = 4'h6;
    localparam logic [3:0] OP_IDCODE   = 4'h7;
    localparam logic [3:0] OP_USERCODE = 4'h8;
    localparam logic [3:0] OP_HIGHZ    = 4'h9;

    typedef enum logic [2:0] {
        SEL_BYPASS   = 3'd0,
        SEL_IDCODE   = 3'd1,
        SEL_USERCODE = 3'd2,
        SEL_SAMPLE   = 3'd3,
        SEL_EXTEST   = 3'd4,
        SEL_INTEST   = 3'd5,
        SEL_CLAMP    = 3'd6,
        SEL_HIGHZ    = 3'd7
    } ir_sel_e;

    // Fixed IEEE 1149.1 capture pattern: bit 0 = 1, bit 1 = 0.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_ir_ctrl_if.sv
// TAP-side strobe bundle and IR outputs; master = TAP FSM / DR mux, slave = IR controller.
interface jtag_ir_ctrl_if #(
    parameter int IR_WIDTH     = 4,
    parameter int STATUS_WIDTH = 2
);
    logic                    TLR;
    logic                    TDI;
    logic                    CLOCKIR;
    logic                    SHIFTIR;
    logic                    UPDATEIR;
    logic [STATUS_WIDTH-1:0] IR_STATUS;
    logic [IR_WIDTH-1:0]     JTAG_IR;
    logic [2:0]              IR_SEL;
    logic                    IR_VALID;
    logic                    TDO;

    modport master (
        output TLR, TDI, CLOCKIR, SHIFTIR, UPDATEIR, IR_STATUS,
        input  JTAG_IR, IR_SEL, IR_VALID, TDO
    );

    modport slave (
        input  TLR, TDI, CLOCKIR, SHIFTIR, UPDATEIR, IR_STATUS,
        output JTAG_IR, IR_SEL, IR_VALID, TDO
    );
endinterface

// File: rtl/jtag_ir_ctrl_decode.sv
// Combinational opcode decode to DR select; all-ones is BYPASS, nonzero upper bits are undefined.
module jtag_ir_decode
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH = 4
) (
    input  logic [IR_WIDTH-1:0] i_opcode,
    output logic [2:0]          o_sel,
    output logic                o_valid
);

    logic [3:0] w_low;
    logic       w_upper_zero;
    logic       w_all_ones;

    // Narrow IRs are zero-extended so the 4-bit opcode table still applies.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_low
            if (gi < IR_WIDTH) begin : g_bit
                assign w_low[gi] = i_opcode[gi];
            end else begin : g_pad
                assign w_low[gi] = 1'b0;
            end
        end
        if (IR_WIDTH > 4) begin : g_upper
            assign w_upper_zero = ~|i_opcode[IR_WIDTH-1:4];
        end else begin : g_no_upper
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    assign w_all_ones = &i_opcode;

    always_comb begin
        o_sel   = SEL_BYPASS;
        o_valid = 1'b0;
        if (w_all_ones) begin
            o_valid = 1'b1;
        end else if (w_upper_zero) begin
            o_valid = 1'b1;
            case (w_low)
                OP_BYPASS:              o_sel = SEL_BYPASS;
                OP_SAMPLE, OP_PRELOAD:  o_sel = SEL_SAMPLE;
                OP_EXTEST:              o_sel = SEL_EXTEST;
                OP_INTEST:              o_sel = SEL_INTEST;
                OP_CLAMP:               o_sel = SEL_CLAMP;
                OP_IDCODE:              o_sel = SEL_IDCODE;
                OP_USERCODE:            o_sel = SEL_USERCODE;
                OP_HIGHZ:               o_sel = SEL_HIGHZ;
                default: begin
                    o_sel   = SEL_BYPASS;
                    o_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/jtag_ir_ctrl.sv
// JTAG instruction register: capture/shift/update with registered TDO and decode.
// Optional JTAG_IR_CAPTURE_STATUS_EN places IR_STATUS at bits [STATUS_WIDTH+1:2] of the capture value.
module jtag_ir_ctrl
    import jtag_pkg::*;
#(
    parameter int         IR_WIDTH     = 4,
    parameter logic [3:0] IR_RESET_OP  = 4'b0111,
    parameter int         STATUS_WIDTH = 2
) (
    input logic           TCK,
    input logic           rst,
    jtag_ir_ctrl_if.slave bus
);

    localparam logic [IR_WIDTH-1:0] RESET_OP    = IR_WIDTH'(IR_RESET_OP);
    localparam logic [IR_WIDTH-1:0] RESET_SHIFT = IR_WIDTH'(IR_CAPTURE);

    logic [IR_WIDTH-1:0] r_shift;
    logic [IR_WIDTH-1:0] r_ir;
    logic [2:0]          r_sel;
    logic                r_valid;
    logic                r_tdo;

    logic [IR_WIDTH-1:0] w_capture;
    logic [2:0]          w_sel;
    logic                w_valid;
    logic [2:0]          w_rst_sel;
    logic                w_rst_valid;

`ifdef JTAG_IR_CAPTURE_STATUS_EN
    assign w_capture = RESET_SHIFT | (IR_WIDTH'(bus.IR_STATUS) << 2);
`else
    logic w_unused_status;
    assign w_unused_status = ^bus.IR_STATUS;
    assign w_capture       = RESET_SHIFT;
`endif

    // Decoding the shift register (not JTAG_IR) lets select/valid land on the update edge.
    jtag_ir_decode #(.IR_WIDTH(IR_WIDTH)) u_decode (
        .i_opcode (r_shift),
        .o_sel    (w_sel),
        .o_valid  (w_valid)
    );

    jtag_ir_decode #(.IR_WIDTH(IR_WIDTH)) u_rst_decode (
        .i_opcode (RESET_OP),
        .o_sel    (w_rst_sel),
        .o_valid  (w_rst_valid)
    );

    always_ff @(posedge TCK or posedge rst) begin
        if (rst) begin
            r_shift <= RESET_SHIFT;
            r_ir    <= RESET_OP;
            r_sel   <= w_rst_sel;
            r_valid <= w_rst_valid;
            r_tdo   <= 1'b0;
        end else if (bus.TLR) begin
            r_shift <= RESET_SHIFT;
            r_ir    <= RESET_OP;
            r_sel   <= w_rst_sel;
            r_valid <= w_rst_valid;
            r_tdo   <= 1'b0;
        end else if (bus.UPDATEIR) begin
            r_ir    <= r_shift;
            r_sel   <= w_sel;
            r_valid <= w_valid;
        end else if (bus.CLOCKIR) begin
            if (bus.SHIFTIR) begin
                r_shift <= {bus.TDI, r_shift[IR_WIDTH-1:1]};
                r_tdo   <= r_shift[0];
            end else begin
                r_shift <= w_capture;
            end
        end
    end

    assign bus.JTAG_IR  = r_ir;
    assign bus.IR_SEL   = r_sel;
    assign bus.IR_VALID = r_valid;
    assign bus.TDO      = r_tdo;

endmodule

// File: tb/tb_jtag_ir_ctrl.sv
// Bench for jtag_ir_ctrl: 4-bit and 8-bit IRs driven in parallel against a bit-stream reference model.
module tb_jtag_ir_ctrl;
    import jtag_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tlr = 1'b0, tdi = 1'b0, cir = 1'b0, sir = 1'b0, uir = 1'b0;
    logic [1:0] status = 2'b00;

    always #5 clk = ~clk;

    jtag_ir_ctrl_if #(.IR_WIDTH(4), .STATUS_WIDTH(2)) bus4 ();
    jtag_ir_ctrl_if #(.IR_WIDTH(8), .STATUS_WIDTH(2)) bus8 ();

    assign bus4.TLR = tlr;  assign bus4.TDI = tdi;  assign bus4.CLOCKIR = cir;
    assign bus4.SHIFTIR = sir;  assign bus4.UPDATEIR = uir;  assign bus4.IR_STATUS = status;
    assign bus8.TLR = tlr;  assign bus8.TDI = tdi;  assign bus8.CLOCKIR = cir;
    assign bus8.SHIFTIR = sir;  assign bus8.UPDATEIR = uir;  assign bus8.IR_STATUS = status;

    jtag_ir_ctrl #(.IR_WIDTH(4), .IR_RESET_OP(4'b0111), .STATUS_WIDTH(2)) dut4 (
        .TCK(clk), .rst(rst), .bus(bus4));
    jtag_ir_ctrl #(.IR_WIDTH(8), .IR_RESET_OP(4'b0111), .STATUS_WIDTH(2)) dut8 (
        .TCK(clk), .rst(rst), .bus(bus8));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: the IR is a FIFO of bits; capture refills it, each shift pops TDO and appends TDI.
    int          W [2] = '{4, 8};
    bit          mq [2][$];
    int unsigned m_ir [2];
    int          m_sel [2];
    bit          m_valid [2];
    bit          m_tdo [2];

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_decode(int w, int unsigned v, output int sel, output bit valid);
        sel = 0; valid = 1'b1;
        if (v == (32'd1 << w) - 1) begin
            sel = 0;
        end else if (v > 15) begin
            valid = 1'b0;
        end else begin
            case (v)
                0:       sel = 0;
                1, 2:    sel = 3;
                3:       sel = 4;
                4:       sel = 5;
                6:       sel = 6;
                7:       sel = 1;
                8:       sel = 2;
                9:       sel = 7;
                default: valid = 1'b0;
            endcase
        end
    endfunction

    function automatic void load_capture(int d, logic [1:0] st);
        mq[d].delete();
        for (int i = 0; i < W[d]; i++) begin
            bit b;
            b = (i == 0);
`ifdef JTAG_IR_CAPTURE_STATUS_EN
            if (i == 2) b = st[0];
            if (i == 3) b = st[1];
`endif
            mq[d].push_back(b);
        end
    endfunction

    function automatic void model_reset(int d);
        load_capture(d, 2'b00);
        m_ir[d] = 7;
        ref_decode(W[d], 7, m_sel[d], m_valid[d]);
        m_tdo[d] = 1'b0;
    endfunction

    function automatic void model_edge(int d);
        if (tlr) begin
            model_reset(d);
        end else if (uir) begin
            int unsigned v;
            v = 0;
            for (int i = 0; i < W[d]; i++) v |= int'(mq[d][i]) << i;
            m_ir[d] = v;
            ref_decode(W[d], v, m_sel[d], m_valid[d]);
        end else if (cir) begin
            if (sir) begin
                m_tdo[d] = mq[d].pop_front();
                mq[d].push_back(tdi);
            end else begin
                load_capture(d, status);
            end
        end
    endfunction

    task automatic check_models();
        cmp($sformatf("cyc%0d w4 JTAG_IR", cyc),  32'(bus4.JTAG_IR),  m_ir[0]);
        cmp($sformatf("cyc%0d w4 IR_SEL", cyc),   32'(bus4.IR_SEL),   m_sel[0]);
        cmp($sformatf("cyc%0d w4 IR_VALID", cyc), 32'(bus4.IR_VALID), 32'(m_valid[0]));
        cmp($sformatf("cyc%0d w4 TDO", cyc),      32'(bus4.TDO),      32'(m_tdo[0]));
        cmp($sformatf("cyc%0d w8 JTAG_IR", cyc),  32'(bus8.JTAG_IR),  m_ir[1]);
        cmp($sformatf("cyc%0d w8 IR_SEL", cyc),   32'(bus8.IR_SEL),   m_sel[1]);
        cmp($sformatf("cyc%0d w8 IR_VALID", cyc), 32'(bus8.IR_VALID), 32'(m_valid[1]));
        cmp($sformatf("cyc%0d w8 TDO", cyc),      32'(bus8.TDO),      32'(m_tdo[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_edge(0);
        model_edge(1);
        check_models();
    endtask

    task automatic step(logic t, logic d, logic c, logic s, logic u);
        tlr = t; tdi = d; cir = c; sir = s; uir = u;
        tick();
    endtask

    task automatic capture();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic update();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Eight LSB-first shifts: the 4-bit IR keeps v[7:4], the 8-bit IR keeps all of v.
    task automatic load8(logic [7:0] v);
        capture();
        for (int i = 0; i < 8; i++) step(1'b0, v[i], 1'b1, 1'b1, 1'b0);
        update();
    endtask

    task automatic check_reset_values(string tag);
        cmp({tag, " w4 JTAG_IR"},  32'(bus4.JTAG_IR),  32'h7);
        cmp({tag, " w4 IR_SEL"},   32'(bus4.IR_SEL),   32'd1);
        cmp({tag, " w4 IR_VALID"}, 32'(bus4.IR_VALID), 32'd1);
        cmp({tag, " w4 TDO"},      32'(bus4.TDO),      32'd0);
        cmp({tag, " w8 JTAG_IR"},  32'(bus8.JTAG_IR),  32'h07);
        cmp({tag, " w8 IR_SEL"},   32'(bus8.IR_SEL),   32'd1);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [2:0] sel;
        logic       valid;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [3:0] seq4;
        logic [7:0] seq8;
        logic [3:0] tdis;
        logic [3:0] tail;

        vecs[0]  = '{4'h0, 3'd0, 1'b1};
        vecs[1]  = '{4'h1, 3'd3, 1'b1};
        vecs[2]  = '{4'h2, 3'd3, 1'b1};
        vecs[3]  = '{4'h3, 3'd4, 1'b1};
        vecs[4]  = '{4'h4, 3'd5, 1'b1};
        vecs[5]  = '{4'h5, 3'd0, 1'b0};
        vecs[6]  = '{4'h6, 3'd6, 1'b1};
        vecs[7]  = '{4'h7, 3'd1, 1'b1};
        vecs[8]  = '{4'h8, 3'd2, 1'b1};
        vecs[9]  = '{4'h9, 3'd7, 1'b1};
        vecs[10] = '{4'hA, 3'd0, 1'b0};
        vecs[11] = '{4'hF, 3'd0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);
        check_reset_values("reset");
        rst = 1'b0;

        // Decode table on the 4-bit IR
        foreach (vecs[k]) begin
            load8({vecs[k].op, vecs[k].op});
            cmp($sformatf("decode op=%h JTAG_IR", vecs[k].op), 32'(bus4.JTAG_IR), 32'(vecs[k].op));
            cmp($sformatf("decode op=%h IR_SEL", vecs[k].op), 32'(bus4.IR_SEL), 32'(vecs[k].sel));
            cmp($sformatf("decode op=%h IR_VALID", vecs[k].op), 32'(bus4.IR_VALID), 32'(vecs[k].valid));
        end

        // TLR returns the IR to IDCODE, even alongside an update strobe
        load8(8'h33);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("tlr JTAG_IR", 32'(bus4.JTAG_IR), 32'h7);
        cmp("tlr IR_SEL", 32'(bus4.IR_SEL), 32'd1);

        // Captured pattern out on TDO; status only appears with the feature enabled
        status = 2'b10;
        capture();
        status = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            seq4[i] = bus4.TDO;
        end
`ifdef JTAG_IR_CAPTURE_STATUS_EN
        cmp("capture tdo seq w4", 32'(seq4), 32'b1001);
`else
        cmp("capture tdo seq w4", 32'(seq4), 32'b0001);
`endif

        // 8-bit IR, 12 shifts: captured 0x01 first, then TDI emerges after the full register
        capture();
        for (int i = 0; i < 12; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            if (i < 4) tdis[i] = b;
            step(1'b0, b, 1'b1, 1'b1, 1'b0);
            if (i < 8) seq8[i] = bus8.TDO;
            else tail[i-8] = bus8.TDO;
        end
        cmp("w8 captured tdo", 32'(seq8), 32'h01);
        cmp("w8 tdi passthrough", 32'(tail), 32'(tdis));

        // Asynchronous reset mid-shift, then a clean restart
        load8(8'h93);
        capture();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #2;
        check_reset_values("async rst");
        model_reset(0);
        model_reset(1);
        rst = 1'b0;
        load8(8'h09);
        cmp("restart w8 IR_SEL", 32'(bus8.IR_SEL), 32'd7);

        // UPDATEIR together with CLOCKIR: update wins, shift register holds
        capture();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Random strobes against the model
        for (int n = 0; n < 400; n++) begin
            status = 2'($urandom);
            step(1'($urandom_range(0, 39) == 0), 1'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
